// File: rtl/fret_sprite_mem_if.sv
// Bus between the fret sprite renderer / game controller (master) and the
// sprite pixel memory (slave): read port, frame sync and streamed load handshake.
interface fret_sprite_mem_if #(
  parameter int AW = 10,
  parameter int PW = 13
);
  logic [AW-1:0] paddr;
  logic [PW-1:0] pdata;
  logic          vsync;
  logic          load_start;
  logic [PW-1:0] load_data;
  logic          load_valid;
  logic          load_ready;
  logic          load_busy;
  logic          load_done;

  modport master (
    output paddr, vsync, load_start, load_data, load_valid,
    input  pdata, load_ready, load_busy, load_done
  );

  modport slave (
    input  paddr, vsync, load_start, load_data, load_valid,
    output pdata, load_ready, load_busy, load_done
  );
endinterface

// File: rtl/fret_sprite_mem.sv
// 32x32 sprite pixel memory with 1-cycle registered read and a streamed reload.
// Define FRET_SPRITE_MEM_DBUF_EN for two banks swapped on vsync; default is one bank.
module fret_sprite_mem #(
  parameter int W     = 32,
  parameter int H     = 32,
  parameter int DEPTH = W * H,
  parameter int PW    = 13
) (
  input  logic                clk,
  input  logic                reset_n,
  fret_sprite_mem_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWAP_WAIT
  } state_t;

`ifdef FRET_SPRITE_MEM_DBUF_EN
  localparam int MAW = AW + 1;
  logic front_q, front_d;
`else
  localparam int MAW = AW;
`endif
  localparam int NWORDS = 1 << MAW;

  state_t        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          load_ready_q, load_ready_d;
  logic          load_busy_q, load_busy_d;
  logic          load_done_q, load_done_d;
  logic [PW-1:0] pdata_q;
  logic          xfer;
  logic          mem_we;
  logic [MAW-1:0] mem_raddr, mem_waddr;

  logic [PW-1:0] mem [NWORDS];

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    load_done_d = 1'b0;
`ifdef FRET_SPRITE_MEM_DBUF_EN
    front_d     = front_q;
`endif
    xfer        = (state_q == LOAD) && bus.load_valid;

    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          waddr_d = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          waddr_d = waddr_q + AW'(1);
          if (waddr_q == AW'(DEPTH - 1)) begin
`ifdef FRET_SPRITE_MEM_DBUF_EN
            state_d = SWAP_WAIT;
`else
            state_d     = IDLE;
            load_done_d = 1'b1;
`endif
          end
        end
      end
      SWAP_WAIT: begin
`ifdef FRET_SPRITE_MEM_DBUF_EN
        // vsync on the final-transfer cycle is seen in LOAD, so it cannot swap.
        if (bus.vsync) begin
          front_d     = ~front_q;
          load_done_d = 1'b1;
          state_d     = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    load_ready_d = (state_d == LOAD);
    load_busy_d  = (state_d != IDLE);
  end

  // Reads use the next front so the swapped bank shows up with load_done.
  always_comb begin
`ifdef FRET_SPRITE_MEM_DBUF_EN
    mem_raddr = {front_d, bus.paddr};
    mem_waddr = {~front_q, waddr_q};
`else
    mem_raddr = bus.paddr;
    mem_waddr = waddr_q;
`endif
    mem_we = xfer & reset_n;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      waddr_q      <= '0;
      load_ready_q <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
`ifdef FRET_SPRITE_MEM_DBUF_EN
      front_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      load_ready_q <= load_ready_d;
      load_busy_q  <= load_busy_d;
      load_done_q  <= load_done_d;
`ifdef FRET_SPRITE_MEM_DBUF_EN
      front_q      <= front_d;
`endif
    end
  end

  // Contents survive reset; only the output register clears (read-first).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= bus.load_data;
    end
    if (!reset_n) begin
      pdata_q <= '0;
    end else begin
      pdata_q <= mem[mem_raddr];
    end
  end

  assign bus.pdata      = pdata_q;
  assign bus.load_ready = load_ready_q;
  assign bus.load_busy  = load_busy_q;
  assign bus.load_done  = load_done_q;

endmodule

// File: tb/tb_fret_sprite_mem.sv
// Randomized bench for fret_sprite_mem against an image-level reference model
// (visible/hidden sprite images, load progress, pending swap).
module tb_fret_sprite_mem;

  localparam int DEPTH = 1024;
`ifdef FRET_SPRITE_MEM_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fret_sprite_mem_if bus ();

  fret_sprite_mem dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: sprite images per bank plus load/swap progress.
  logic [12:0] img   [2][DEPTH];
  bit          known [2][DEPTH];
  bit m_front, m_loading, m_pending;
  int m_count;
  int dut_xfers, done_seen, tick_no, last_xfer_tick, done_tick, swap_tick;

  task automatic check_eq(string tag, int got, int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: predict the effect of the current inputs, take the edge, compare.
  task automatic tick();
    logic [12:0] exp_pdata;
    bit chk_pdata, exp_done, exp_ready, exp_busy, swap;
    int rb, wb;
    exp_pdata = '0;
    chk_pdata = 1'b1;
    exp_done  = 1'b0;
    if (bus.load_valid && bus.load_ready) dut_xfers++;
    if (!reset_n) begin
      m_front   = 1'b0;
      m_loading = 1'b0;
      m_pending = 1'b0;
      m_count   = 0;
    end else begin
      swap = DBUF && m_pending && bus.vsync;
      if (swap) begin
        m_front   = ~m_front;
        m_pending = 1'b0;
        exp_done  = 1'b1;
      end
      rb = DBUF ? int'(m_front) : 0;
      wb = DBUF ? int'(!m_front) : 0;
      exp_pdata = img[rb][bus.paddr];
      chk_pdata = known[rb][bus.paddr];
      if (m_loading && bus.load_valid) begin
        img[wb][m_count]   = bus.load_data;
        known[wb][m_count] = 1'b1;
        m_count++;
        if (m_count == DEPTH) begin
          m_loading      = 1'b0;
          m_count        = 0;
          last_xfer_tick = tick_no;
          if (DBUF) m_pending = 1'b1;
          else      exp_done  = 1'b1;
        end
      end else if (!m_loading && !m_pending && bus.load_start) begin
        m_loading = 1'b1;
        m_count   = 0;
      end
    end
    exp_ready = m_loading;
    exp_busy  = m_loading || m_pending;
    @(posedge clk);
    #1;
    if (chk_pdata) check_eq("pdata", bus.pdata, exp_pdata);
    check_eq("load_ready", bus.load_ready, exp_ready);
    check_eq("load_busy", bus.load_busy, exp_busy);
    check_eq("load_done", bus.load_done, exp_done);
    if (bus.load_done) begin
      done_seen++;
      done_tick = tick_no;
    end
    tick_no++;
  endtask

  // data_mode: 0 index, 1 random, 2 constant 0x1ABC.
  // valid_mode: 0 continuous, 1 alternate + 50-cycle stall at 512, 2 random.
  task automatic run_load(int data_mode, int valid_mode, bit noisy, int abort_at);
    int stall;
    bit v;
    stall     = 0;
    dut_xfers = 0;
    bus.load_start = 1'b1;
    bus.load_valid = 1'b0;
    bus.vsync      = 1'b0;
    bus.paddr      = 10'($urandom_range(0, DEPTH - 1));
    tick();
    bus.load_start = 1'b0;
    for (int cyc = 0; cyc < 6000 && m_loading; cyc++) begin
      case (valid_mode)
        0:       v = 1'b1;
        1: begin
          v = (cyc % 2) == 0;
          if (m_count == 512 && stall < 50) begin
            v = 1'b0;
            stall++;
          end
        end
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.load_valid = v;
      case (data_mode)
        0:       bus.load_data = 13'(m_count);
        1:       bus.load_data = 13'($urandom);
        default: bus.load_data = 13'h1ABC;
      endcase
      bus.vsync      = noisy && (($urandom_range(0, 7) == 0) || (m_count == DEPTH - 1));
      bus.load_start = noisy && ($urandom_range(0, 3) == 0);
      bus.paddr      = 10'($urandom_range(0, DEPTH - 1));
      if (abort_at >= 0 && m_count == abort_at) reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
    end
    bus.load_valid = 1'b0;
    bus.load_start = 1'b0;
    bus.vsync      = 1'b0;
    check_eq("load_ready_after_load", bus.load_ready, 0);
  endtask

  task automatic pulse_vsync();
    bus.vsync = 1'b1;
    bus.paddr = 10'd5;
    swap_tick = tick_no;
    tick();
    bus.vsync = 1'b0;
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a++) begin
      bus.paddr = 10'(a);
      tick();
    end
    for (int i = 0; i < 256; i++) begin
      bus.paddr = 10'($urandom_range(0, DEPTH - 1));
      bus.vsync = 1'($urandom_range(0, 1));
      tick();
    end
    bus.vsync = 1'b0;
  endtask

  initial begin
    logic [12:0] old5;
    bus.paddr = '0; bus.vsync = 1'b0; bus.load_start = 1'b0;
    bus.load_data = '0; bus.load_valid = 1'b0;
    m_front = 1'b0; m_loading = 1'b0; m_pending = 1'b0; m_count = 0;
    tick_no = 0; done_seen = 0; dut_xfers = 0;
    last_xfer_tick = -1; done_tick = -1; swap_tick = -1;

    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.paddr      = 10'($urandom_range(0, DEPTH - 1));
      bus.load_start = 1'($urandom_range(0, 1));
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.vsync      = 1'($urandom_range(0, 1));
      tick();
    end
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.vsync = 1'b0;
    reset_n = 1'b1;
    tick();
    $display("[TB] reset: done");

    run_load(1, 2, 1'b1, -1);
    pulse_vsync();
    sweep();
    $display("[TB] load1 random data/valid/vsync: done");

    old5 = img[DBUF ? int'(m_front) : 0][5];
    done_seen = 0;
    run_load(0, 0, 1'b0, -1);
    check_eq("xfers_load2", dut_xfers, DEPTH);
    bus.paddr = 10'd5;
    tick();
    tick();
    check_eq("px5_before_vsync", bus.pdata, DBUF ? int'(old5) : 5);
    check_eq("busy_before_vsync", bus.load_busy, int'(DBUF));
    check_eq("ready_before_vsync", bus.load_ready, 0);
    pulse_vsync();
    check_eq("px5_after_vsync", bus.pdata, 5);
    check_eq("done_on_vsync", bus.load_done, int'(DBUF));
    bus.paddr = 10'd1023;
    tick();
    check_eq("px1023_after_vsync", bus.pdata, 1023);
    check_eq("busy_after_vsync", bus.load_busy, 0);
    tick();
    tick();
    check_eq("done_pulses_load2", done_seen, 1);
    $display("[TB] load2 ramp 0..1023 + swap: done");

    run_load(1, 1, 1'b0, -1);
    check_eq("xfers_load3", dut_xfers, DEPTH);
    pulse_vsync();
    sweep();
    $display("[TB] load3 toggled valid + stall: done");

    done_seen = 0;
    run_load(1, 0, 1'b0, 300);
    pulse_vsync();
    check_eq("done_after_abort", done_seen, 0);
    check_eq("ready_after_abort", bus.load_ready, 0);
    check_eq("busy_after_abort", bus.load_busy, 0);
    sweep();
    $display("[TB] load4 reset at waddr 300: done");

    done_seen = 0;
    run_load(2, 0, 1'b0, -1);
    pulse_vsync();
    tick();
    check_eq("done_pulses_load5", done_seen, 1);
    check_eq("done_timing_load5", done_tick, DBUF ? swap_tick : last_xfer_tick);
    for (int a = 0; a < DEPTH; a++) begin
      bus.paddr = 10'(a);
      tick();
      check_eq("px_1abc", bus.pdata, 'h1ABC);
    end
    $display("[TB] load5 constant 0x1ABC: done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
